// File: rtl/adder_result_checker.sv
// ---------------------------------------------------------------------------
// adder_result_checker
//   Scoreboard placed directly downstream of a pipelined adder. Every accepted
//   operand launch produces a golden {carry, sum}. That value is delayed by
//   LATENCY edges so that it meets the adder result for the same launch. The
//   checker then compares the two, counts checks and errors, and records the
//   first mismatch of the run.
//
// Parameters
//   W        operand / sum width
//   LATENCY  clock edges from operand launch to the sampled adder result (>=1)
//   CNT_W    width of all counters and of n_checks_i
//
// Ports
//   clk               clock, all logic on the rising edge
//   reset             synchronous, active-high
//   start_i           one-cycle pulse: clear results and begin a new run
//   n_checks_i        number of launches to check, sampled on start_i
//   in_valid_i        an operand launch is being driven to the adder this cycle
//   in_a_i, in_b_i    operands as driven to the adder
//   in_cin_i          carry-in as driven to the adder
//   dut_sum_i         adder sum output
//   dut_cout_i        adder carry output
//   busy_o            a run is accepting launches or draining
//   done_o            the run has finished and results are held
//   pass_o            done with no mismatches
//   check_count_o     comparisons completed
//   err_count_o       mismatching comparisons, saturating
//   first_err_idx_o   check_count value at the first mismatch
//   first_err_exp_o   golden {cout,sum} at the first mismatch
//   first_err_got_o   adder {cout,sum} at the first mismatch
// ---------------------------------------------------------------------------
module adder_result_checker #(
  parameter int W       = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_checks_i,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_a_i,
  input  logic [W-1:0]     in_b_i,
  input  logic             in_cin_i,
  input  logic [W-1:0]     dut_sum_i,
  input  logic             dut_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] check_count_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [W:0]       first_err_exp_o,
  output logic [W:0]       first_err_got_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] nChecks_q;
  logic [CNT_W-1:0] launchCnt_q,   launchCnt_d;
  logic [CNT_W-1:0] checkCnt_q,    checkCnt_d;
  logic [CNT_W-1:0] errCnt_q,      errCnt_d;
  logic [CNT_W-1:0] firstErrIdx_q, firstErrIdx_d;
  logic [W:0]       firstErrExp_q, firstErrExp_d;
  logic [W:0]       firstErrGot_q, firstErrGot_d;
  logic [LATENCY-1:0] pipeV_q, pipeV_d;
  logic [W:0]       pipeExp_q [LATENCY];
  logic [W:0]       pipeExp_d [LATENCY];

  logic       launch;
  logic       compare;
  logic       mismatch;
  logic [W:0] golden;
  logic [W:0] got;

  // Golden result at W+1 bits so the carry lands in the top bit. A launch
  // only counts while running and the quota for this run is not yet used.
  // The oldest pipe entry lines up with the adder output present this cycle.
  always_comb begin
    golden   = {1'b0, in_a_i} + {1'b0, in_b_i} + {{W{1'b0}}, in_cin_i};
    launch   = in_valid_i && (state_q == RUN) && (launchCnt_q < nChecks_q);
    compare  = pipeV_q[LATENCY-1];
    got      = {dut_cout_i, dut_sum_i};
    mismatch = compare && (got != pipeExp_q[LATENCY-1]);
  end

  // Next-state datapath: shift the golden pipe, advance counters, and capture
  // the first mismatch. An error count of zero marks a mismatch as the first
  // of the run, because the count saturates and never wraps back to zero.
  always_comb begin
    pipeV_d[0]   = launch;
    pipeExp_d[0] = golden;
    for (int i = 1; i < LATENCY; i++) begin
      pipeV_d[i]   = pipeV_q[i-1];
      pipeExp_d[i] = pipeExp_q[i-1];
    end
    launchCnt_d   = launchCnt_q + CNT_W'(launch);
    checkCnt_d    = checkCnt_q + CNT_W'(compare);
    errCnt_d      = errCnt_q;
    firstErrIdx_d = firstErrIdx_q;
    firstErrExp_d = firstErrExp_q;
    firstErrGot_d = firstErrGot_q;
    if (mismatch) begin
      if (errCnt_q != '1) begin
        errCnt_d = errCnt_q + 1'b1;
      end
      if (errCnt_q == '0) begin
        firstErrIdx_d = checkCnt_q;
        firstErrExp_d = pipeExp_q[LATENCY-1];
        firstErrGot_d = got;
      end
    end
  end

  // State register. start_i overrides any launch or compare in the same
  // cycle and discards in-flight entries. RUN drains once the last launch is
  // accepted. DRAIN finishes once no golden entry is left in the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      nChecks_q     <= '0;
      launchCnt_q   <= '0;
      checkCnt_q    <= '0;
      errCnt_q      <= '0;
      firstErrIdx_q <= '0;
      firstErrExp_q <= '0;
      firstErrGot_q <= '0;
      pipeV_q       <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipeExp_q[i] <= '0;
      end
    end else if (start_i) begin
      state_q       <= (n_checks_i == '0) ? DONE : RUN;
      nChecks_q     <= n_checks_i;
      launchCnt_q   <= '0;
      checkCnt_q    <= '0;
      errCnt_q      <= '0;
      firstErrIdx_q <= '0;
      firstErrExp_q <= '0;
      firstErrGot_q <= '0;
      pipeV_q       <= '0;
    end else begin
      launchCnt_q   <= launchCnt_d;
      checkCnt_q    <= checkCnt_d;
      errCnt_q      <= errCnt_d;
      firstErrIdx_q <= firstErrIdx_d;
      firstErrExp_q <= firstErrExp_d;
      firstErrGot_q <= firstErrGot_d;
      pipeV_q       <= pipeV_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipeExp_q[i] <= pipeExp_d[i];
      end
      case (state_q)
        RUN: begin
          if (launchCnt_d == nChecks_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipeV_q == '0) begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // Status and results are decoded directly from registers.
  always_comb begin
    busy_o          = (state_q == RUN) || (state_q == DRAIN);
    done_o          = (state_q == DONE);
    pass_o          = (state_q == DONE) && (errCnt_q == '0);
    check_count_o   = checkCnt_q;
    err_count_o     = errCnt_q;
    first_err_idx_o = firstErrIdx_q;
    first_err_exp_o = firstErrExp_q;
    first_err_got_o = firstErrGot_q;
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// ---------------------------------------------------------------------------
// tb_adder_result_checker
//   Drives adder_result_checker with a small registered adder in the loop.
//   The adder has input and output registers, which gives a latency of two.
//   Faults can be injected into the adder: a per-launch sum bit0 flip, and a
//   carry-out stuck at 0. Expected run results come from a simple model. The
//   model takes the first n launches of a run, computes a+b+cin, applies the
//   injected fault, and counts the resulting mismatches.
// ---------------------------------------------------------------------------
module tb_adder_result_checker;

  localparam int W       = 32;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] nChecks;
  logic             inValid;
  logic [W-1:0]     inA;
  logic [W-1:0]     inB;
  logic             inCin;
  logic [W-1:0]     dutSum;
  logic             dutCout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] checkCount;
  logic [CNT_W-1:0] errCount;
  logic [CNT_W-1:0] firstErrIdx;
  logic [W:0]       firstErrExp;
  logic [W:0]       firstErrGot;

  logic             flipIn;
  logic             coutStuck;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] qA[$];
  logic [W-1:0] qB[$];
  logic         qC[$];
  logic         qF[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   expSum;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  adder_result_checker #(
    .W       (W),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start),
    .n_checks_i      (nChecks),
    .in_valid_i      (inValid),
    .in_a_i          (inA),
    .in_b_i          (inB),
    .in_cin_i        (inCin),
    .dut_sum_i       (dutSum),
    .dut_cout_i      (dutCout),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .check_count_o   (checkCount),
    .err_count_o     (errCount),
    .first_err_idx_o (firstErrIdx),
    .first_err_exp_o (firstErrExp),
    .first_err_got_o (firstErrGot)
  );

  // Registered adder in the loop, with optional injected faults.
  logic [W-1:0] aR, bR;
  logic         cR, flipR;
  logic [W:0]   addRes;

  assign addRes = {1'b0, aR} + {1'b0, bR} + {{W{1'b0}}, cR};

  always_ff @(posedge clk) begin
    if (reset) begin
      aR      <= '0;
      bR      <= '0;
      cR      <= 1'b0;
      flipR   <= 1'b0;
      dutSum  <= '0;
      dutCout <= 1'b0;
    end else begin
      aR      <= inA;
      bR      <= inB;
      cR      <= inCin;
      flipR   <= flipIn;
      dutSum  <= addRes[W-1:0] ^ {{(W-1){1'b0}}, flipR};
      dutCout <= addRes[W] & ~coutStuck;
    end
  end

  // Drive one cycle of inputs, then wait for the next edge plus a small
  // settle time so that outputs are sampled away from the edge.
  task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] n,
                               input logic v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c,
                               input logic f);
    start   = st;
    nChecks = n;
    inValid = v;
    inA     = a;
    inB     = b;
    inCin   = c;
    flipIn  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
  endtask

  task automatic startRun(input logic [CNT_W-1:0] n);
    applyStimulus(1'b1, n, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic clearQueues();
    qA.delete();
    qB.delete();
    qC.delete();
    qF.delete();
  endtask

  task automatic pushOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic f);
    qA.push_back(a);
    qB.push_back(b);
    qC.push_back(c);
    qF.push_back(f);
  endtask

  task automatic driveOps(input int gapPct);
    for (int i = 0; i < qA.size(); i++) begin
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gapPct; g++) begin
        idleCycle();
      end
      applyStimulus(1'b0, '0, 1'b1, qA[i], qB[i], qC[i], qF[i]);
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      idleCycle();
      k++;
    end
    checkOutput({tag, ".doneReached"}, 64'(done), 64'd1);
  endtask

  // Model: only the first n launches of the run are checked. Each check
  // compares the fault-adjusted adder result against a+b+cin.
  task automatic checkResults(input string tag, input int n);
    int         m;
    int         expErr;
    int         expIdx;
    logic [W:0] e, g, expE, expG;
    m      = (n < qA.size()) ? n : qA.size();
    expErr = 0;
    expIdx = 0;
    expE   = '0;
    expG   = '0;
    for (int i = 0; i < m; i++) begin
      e = {1'b0, qA[i]} + {1'b0, qB[i]} + (W+1)'(qC[i]);
      g = e ^ (W+1)'(qF[i]);
      if (coutStuck) g[W] = 1'b0;
      if (g != e) begin
        if (expErr == 0) begin
          expIdx = i;
          expE   = e;
          expG   = g;
        end
        if (expErr < 32'hFFFF) expErr++;
      end
    end
    checkOutput({tag, ".done"},        64'(done),        64'd1);
    checkOutput({tag, ".busy"},        64'(busy),        64'd0);
    checkOutput({tag, ".checkCount"},  64'(checkCount),  64'(m));
    checkOutput({tag, ".errCount"},    64'(errCount),    64'(expErr));
    checkOutput({tag, ".pass"},        64'(pass),        64'(expErr == 0));
    checkOutput({tag, ".firstErrIdx"}, 64'(firstErrIdx), 64'(expIdx));
    checkOutput({tag, ".firstErrExp"}, 64'(firstErrExp), 64'(expE));
    checkOutput({tag, ".firstErrGot"}, 64'(firstErrGot), 64'(expG));
  endtask

  initial begin
    reset     = 1'b1;
    coutStuck = 1'b0;
    start     = 1'b0;
    nChecks   = '0;
    inValid   = 1'b0;
    inA       = '0;
    inB       = '0;
    inCin     = 1'b0;
    flipIn    = 1'b0;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 33'h0_0000_0008};
    vecs[5] = '{32'h0000_0007, 32'h0000_0008, 1'b1, 33'h0_0000_0010};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
    vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_0000_0000};
    vecs[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3569};

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset.busy",       64'(busy),        64'd0);
    checkOutput("reset.done",       64'(done),        64'd0);
    checkOutput("reset.pass",       64'(pass),        64'd0);
    checkOutput("reset.checkCount", 64'(checkCount),  64'd0);
    checkOutput("reset.errCount",   64'(errCount),    64'd0);
    checkOutput("reset.firstExp",   64'(firstErrExp), 64'd0);
    reset = 1'b0;

    // Launches while IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
    end
    checkOutput("idle.checkCount", 64'(checkCount), 64'd0);
    checkOutput("idle.busy",       64'(busy),       64'd0);

    // Golden table: each vector is a single-check run with sum bit0 flipped,
    // so the captured first mismatch exposes the golden value.
    for (int i = 0; i < 9; i++) begin
      startRun(16'd1);
      applyStimulus(1'b0, '0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      waitDone($sformatf("vec%0d", i), 10);
      checkOutput($sformatf("vec%0d.exp", i), 64'(firstErrExp), 64'(vecs[i].expSum));
      checkOutput($sformatf("vec%0d.got", i), 64'(firstErrGot), 64'(vecs[i].expSum ^ 33'd1));
      checkOutput($sformatf("vec%0d.err", i), 64'(errCount), 64'd1);
      checkOutput($sformatf("vec%0d.cnt", i), 64'(checkCount), 64'd1);
    end

    // Four clean launches; done six edges after the first launch.
    clearQueues();
    pushOp(32'h1, 32'h1, 1'b0, 1'b0);
    pushOp(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    pushOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    pushOp(32'h0, 32'h0, 1'b0, 1'b0);
    startRun(16'd4);
    checkOutput("t1.busyAfterStart", 64'(busy), 64'd1);
    driveOps(0);
    idleCycle();
    idleCycle();
    checkOutput("t1.doneEarly", 64'(done), 64'd0);
    idleCycle();
    checkOutput("t1.doneOnTime", 64'(done), 64'd1);
    checkResults("t1", 4);

    // Second of three results has sum bit0 inverted.
    clearQueues();
    pushOp(32'd5, 32'd3, 1'b0, 1'b0);
    pushOp(32'd7, 32'd8, 1'b1, 1'b1);
    pushOp(32'd2, 32'd2, 1'b0, 1'b0);
    startRun(16'd3);
    driveOps(0);
    waitDone("t2", 10);
    checkResults("t2", 3);
    checkOutput("t2.idx", 64'(firstErrIdx), 64'd1);
    checkOutput("t2.exp", 64'(firstErrExp), 64'h0_0000_0010);
    checkOutput("t2.got", 64'(firstErrGot), 64'h0_0000_0011);

    // Ten back-to-back launches with quota six; the extra four carry faults.
    clearQueues();
    for (int i = 0; i < 10; i++) begin
      pushOp($urandom, $urandom, 1'($urandom), (i >= 6));
    end
    startRun(16'd6);
    driveOps(0);
    waitDone("t3", 10);
    checkResults("t3", 6);
    checkOutput("t3.cnt6", 64'(checkCount), 64'd6);

    // Zero-length run finishes at once and never reports busy.
    startRun(16'd0);
    checkOutput("t4.done", 64'(done), 64'd1);
    checkOutput("t4.pass", 64'(pass), 64'd1);
    checkOutput("t4.busy", 64'(busy), 64'd0);
    checkOutput("t4.cnt",  64'(checkCount), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b1);
    idleCycle();
    idleCycle();
    checkOutput("t4.cntHold", 64'(checkCount), 64'd0);
    checkOutput("t4.busyHold", 64'(busy), 64'd0);

    // Restart with two faulty results in flight and a faulty launch on the
    // start cycle; none of them may be compared.
    startRun(16'd3);
    applyStimulus(1'b0, '0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 32'h30, 32'h40, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd3, 1'b1, 32'h50, 32'h60, 1'b0, 1'b1);
    checkOutput("t5.cntCleared", 64'(checkCount), 64'd0);
    clearQueues();
    for (int i = 0; i < 3; i++) begin
      pushOp($urandom, $urandom, 1'($urandom), 1'b0);
    end
    driveOps(0);
    waitDone("t5", 10);
    checkResults("t5", 3);

    // Reset mid-run after a mismatch has been captured.
    startRun(16'd5);
    applyStimulus(1'b0, '0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 32'h2, 32'h2, 1'b0, 1'b0);
    idleCycle();
    checkOutput("rst.errBefore", 64'(errCount), 64'd1);
    reset = 1'b1;
    idleCycle();
    reset = 1'b0;
    checkOutput("rst.busy",     64'(busy),        64'd0);
    checkOutput("rst.done",     64'(done),        64'd0);
    checkOutput("rst.cnt",      64'(checkCount),  64'd0);
    checkOutput("rst.err",      64'(errCount),    64'd0);
    checkOutput("rst.firstExp", 64'(firstErrExp), 64'd0);
    checkOutput("rst.firstGot", 64'(firstErrGot), 64'd0);

    // Randomised runs with gaps and random fault flips.
    for (int r = 0; r < 25; r++) begin
      int n;
      int extra;
      n     = $urandom_range(1, 20);
      extra = $urandom_range(0, 5);
      clearQueues();
      for (int i = 0; i < n + extra; i++) begin
        pushOp($urandom, $urandom, 1'($urandom), ($urandom_range(0, 99) < 20));
      end
      startRun(CNT_W'(n));
      driveOps(30);
      waitDone($sformatf("rnd%0d", r), 20);
      checkResults($sformatf("rnd%0d", r), n);
    end

    // Carry stuck low on every result of a maximum-length run.
    coutStuck = 1'b1;
    clearQueues();
    for (int i = 0; i < 32'h10000; i++) begin
      pushOp(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    end
    startRun(16'hFFFF);
    driveOps(0);
    waitDone("t6", 10);
    checkResults("t6", 32'hFFFF);
    checkOutput("t6.err", 64'(errCount),    64'hFFFF);
    checkOutput("t6.idx", 64'(firstErrIdx), 64'd0);
    checkOutput("t6.exp", 64'(firstErrExp), 64'h1_0000_0000);
    checkOutput("t6.got", 64'(firstErrGot), 64'h0_0000_0000);
    coutStuck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
